read_handler: RTL and testbench

READ_HANDLER -- requirements
Module: read_handler

---
 rtl/read_handler.sv | 82 ++++++++
 tb/tb_read_handler.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/read_handler.sv
// Read-side pointer logic of an async FIFO: write-pointer sync, empty/count flags.
// Optional almost_empty output enabled by READ_HANDLER_ALMOST_EMPTY_EN.
module read_handler #(
  parameter int PTR_WIDTH = 16,
  parameter int AE_THRESH = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [PTR_WIDTH:0]   wr_ptr_gray,
  input  logic                 rd_en,
  output logic                 empty,
  output logic                 rd_underflow,
  output logic [PTR_WIDTH:0]   bin_rd_ptr,
  output logic [PTR_WIDTH:0]   gray_rd_ptr,
`ifdef READ_HANDLER_ALMOST_EMPTY_EN
  output logic [PTR_WIDTH:0]   rd_count,
  output logic                 almost_empty
`else
  output logic [PTR_WIDTH:0]   rd_count
`endif
);

  localparam int W = PTR_WIDTH + 1;

  if (AE_THRESH < 0 || AE_THRESH > (1 << PTR_WIDTH)) begin : g_bad_thresh
    $error("read_handler: AE_THRESH out of range");
  end

  logic [W-1:0] sync0;
  logic [W-1:0] sync1;
  logic [W-1:0] wbin;
  logic [W-1:0] rbin_next;
  logic [W-1:0] rgray_next;
  logic [W-1:0] count_next;
  logic         rinc;

  // Bit i of binary is the XOR of all Gray bits at or above i
  always_comb begin
    wbin = '0;
    for (int i = 0; i < W; i++) begin
      wbin[i] = ^(sync1 >> i);
    end
  end

  assign rinc       = rd_en & ~empty;
  assign rbin_next  = bin_rd_ptr + W'(rinc);
  assign rgray_next = rbin_next ^ (rbin_next >> 1);
  assign count_next = wbin - rbin_next;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync0        <= '0;
      sync1        <= '0;
      bin_rd_ptr   <= '0;
      gray_rd_ptr  <= '0;
      rd_count     <= '0;
      empty        <= 1'b1;
      rd_underflow <= 1'b0;
    end else begin
      sync0        <= wr_ptr_gray;
      sync1        <= sync0;
      bin_rd_ptr   <= rbin_next;
      gray_rd_ptr  <= rgray_next;
      rd_count     <= count_next;
      empty        <= (rgray_next == sync1);
      rd_underflow <= rd_en & empty;
    end
  end

`ifdef READ_HANDLER_ALMOST_EMPTY_EN
  localparam logic [W-1:0] AE_LIM = W'(AE_THRESH);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      almost_empty <= 1'b1;
    end else begin
      almost_empty <= (count_next <= AE_LIM);
    end
  end
`endif

endmodule

// File: tb/tb_read_handler.sv
// Bench for read_handler: directed scenarios plus random traffic
// checked against an integer pointer/occupancy model.
module tb_read_handler;

  localparam int PW  = 4;
  localparam int W   = PW + 1;
  localparam int AE  = 2;
  localparam int MOD = 32;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         rd_en = 1'b0;
  logic [W-1:0] wr_ptr_gray = '0;
  logic         empty;
  logic         rd_underflow;
  logic [W-1:0] bin_rd_ptr;
  logic [W-1:0] gray_rd_ptr;
  logic [W-1:0] rd_count;
`ifdef READ_HANDLER_ALMOST_EMPTY_EN
  logic         almost_empty;
`endif

  read_handler #(.PTR_WIDTH(PW), .AE_THRESH(AE)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .wr_ptr_gray  (wr_ptr_gray),
    .rd_en        (rd_en),
    .empty        (empty),
    .rd_underflow (rd_underflow),
    .bin_rd_ptr   (bin_rd_ptr),
    .gray_rd_ptr  (gray_rd_ptr),
`ifdef READ_HANDLER_ALMOST_EMPTY_EN
    .rd_count     (rd_count),
    .almost_empty (almost_empty)
`else
    .rd_count     (rd_count)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: write pointer as seen two edges late, read pointer, flags
  int m_s0, m_s1, m_r, m_cnt;
  bit m_empty, m_uf;
  int wptr;
  logic [W-1:0] prev_g;

  function automatic logic [W-1:0] gray(input int b);
    logic [W-1:0] v;
    v = W'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic setw(input int v);
    wptr = v % MOD;
    wr_ptr_gray = gray(wptr);
  endtask

  task automatic model_reset();
    m_s0 = 0; m_s1 = 0; m_r = 0; m_cnt = 0;
    m_empty = 1'b1; m_uf = 1'b0;
    prev_g = '0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
    chk({tag, "_count"}, 32'(rd_count), 32'd0);
    chk({tag, "_bin"}, 32'(bin_rd_ptr), 32'd0);
    chk({tag, "_gray"}, 32'(gray_rd_ptr), 32'd0);
    chk({tag, "_uf"}, 32'(rd_underflow), 32'd0);
`ifdef READ_HANDLER_ALMOST_EMPTY_EN
    chk({tag, "_ae"}, 32'(almost_empty), 32'd1);
`endif
  endtask

  task automatic tick();
    int w;
    bit acc;
    @(posedge clk);
    w     = m_s1;
    acc   = rd_en && !m_empty;
    m_uf  = rd_en && m_empty;
    m_r   = (m_r + int'(acc)) % MOD;
    m_s1  = m_s0;
    m_s0  = wptr;
    m_empty = (m_r == w);
    m_cnt = (w - m_r + MOD) % MOD;
    #1;
    chk("empty", 32'(empty), 32'(m_empty));
    chk("rd_count", 32'(rd_count), 32'(m_cnt));
    chk("bin_rd_ptr", 32'(bin_rd_ptr), 32'(m_r));
    chk("gray_rd_ptr", 32'(gray_rd_ptr), 32'(gray(m_r)));
    chk("rd_underflow", 32'(rd_underflow), 32'(m_uf));
    chk("gray_step", 32'($countones(gray_rd_ptr ^ prev_g) <= 1), 32'd1);
`ifdef READ_HANDLER_ALMOST_EMPTY_EN
    chk("almost_empty", 32'(almost_empty), 32'(m_cnt <= AE));
`endif
    prev_g = gray_rd_ptr;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    rd_en = 1'b0;
    setw(0);
    model_reset();
    #1;
    chk_reset_vals("rst");
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    int guard;
    model_reset();
    setw(0);
    #12;
    chk_reset_vals("por");
    rstn = 1'b1;

    // Idle after reset
    tick();
    tick();

    // New write visible after two sync stages
    setw(1);
    tick();
    chk("lat_e1", 32'(empty), 32'd1);
    tick();
    chk("lat_e2", 32'(empty), 32'd1);
    tick();
    chk("lat_e3", 32'(empty), 32'd0);
    chk("lat_cnt", 32'(rd_count), 32'd1);
    rd_en = 1'b1;
    tick();
    chk("rd1_bin", 32'(bin_rd_ptr), 32'd1);
    chk("rd1_gray", 32'(gray_rd_ptr), 32'd1);
    chk("rd1_empty", 32'(empty), 32'd1);
    rd_en = 1'b0;

    // Full FIFO drained with 17 reads
    do_reset();
    setw(16);
    tick(); tick(); tick();
    chk("full_cnt", 32'(rd_count), 32'd16);
    rd_en = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      tick();
      chk("drain_cnt", 32'(rd_count), 32'(k >= 16 ? 0 : 16 - k));
      chk("drain_bin", 32'(bin_rd_ptr), 32'(k >= 16 ? 16 : k));
      chk("drain_uf", 32'(rd_underflow), 32'(k == 17));
    end

    // Walk read pointer up to 31
    guard = 0;
    while (m_r != 31 && guard < 60) begin
      if (wptr != 31) setw(wptr + 1);
      tick();
      guard++;
    end
    chk("wrap_reach31", 32'(m_r), 32'd31);
    rd_en = 1'b0;
    tick(); tick();
    setw(0);
    tick(); tick(); tick();
    setw(1);
    tick(); tick(); tick();
    chk("wrap_pre_cnt", 32'(rd_count), 32'd2);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("wrap_bin", 32'(bin_rd_ptr), 32'd0);
    chk("wrap_gray", 32'(gray_rd_ptr), 32'd0);
    chk("wrap_empty", 32'(empty), 32'd0);
    chk("wrap_cnt", 32'(rd_count), 32'd1);

    // Random traffic, writer never exceeds 16 unread words
    for (int n = 0; n < 600; n++) begin
      int wp, rp;
      wp = (n < 200) ? 70 : (n < 400) ? 30 : 50;
      rp = (n < 200) ? 30 : (n < 400) ? 70 : 50;
      rd_en = ($urandom_range(99) < rp);
      if ($urandom_range(99) < wp && ((wptr - m_r + MOD) % MOD) < 16)
        setw(wptr + 1);
      tick();
    end
    rd_en = 1'b0;

    // Asynchronous reset mid-cycle
    do_reset();
    setw(5);
    tick(); tick(); tick();
    chk("pre_arst_cnt", 32'(rd_count), 32'd5);
    @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    chk_reset_vals("arst");
    model_reset();
    setw(0);
    @(negedge clk);
    rstn = 1'b1;
    tick(); tick();

    // Occupancy 4 -> 3 -> 2 through reads
    do_reset();
    setw(4);
    tick(); tick(); tick();
    chk("ae_cnt4", 32'(rd_count), 32'd4);
`ifdef READ_HANDLER_ALMOST_EMPTY_EN
    chk("ae_4", 32'(almost_empty), 32'd0);
`endif
    rd_en = 1'b1;
    tick();
    chk("ae_cnt3", 32'(rd_count), 32'd3);
`ifdef READ_HANDLER_ALMOST_EMPTY_EN
    chk("ae_3", 32'(almost_empty), 32'd0);
`endif
    tick();
    chk("ae_cnt2", 32'(rd_count), 32'd2);
`ifdef READ_HANDLER_ALMOST_EMPTY_EN
    chk("ae_2", 32'(almost_empty), 32'd1);
`endif
    rd_en = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
